// File: rtl/rx_slot_pkg.sv
// Shared slot parameters and types for the RX slot descriptor path.
// Used by the injector, the DMA and the core-side slot logic.
package rx_slot_pkg;

  localparam int SLOT_COUNT_DEF = 16;
  localparam int SLOT_WIDTH_DEF = $clog2(SLOT_COUNT_DEF);
  localparam int ADDR_WIDTH_DEF = 7;

  typedef logic [SLOT_WIDTH_DEF-1:0] slot_idx_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] slot_addr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } inj_state_e;

endpackage

// File: rtl/slot_free_fifo.sv
// Free-slot index FIFO; push and pop may coincide, no bypass path.
// Depth is a power of two so the pointers wrap naturally.
module slot_free_fifo
  import rx_slot_pkg::*;
#(
  parameter int DEPTH = SLOT_COUNT_DEF,
  parameter int W     = SLOT_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic [W:0]   count_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] wr_q, rd_q;
  logic [W:0]   count_q;
  logic         do_pop, do_push;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && ((count_q != (W+1)'(DEPTH)) || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rx_slot_desc_injector.sv
// Issues one RX descriptor per free packet slot and recycles slots
// as the core releases them.
module rx_slot_desc_injector
  import rx_slot_pkg::*;
#(
  parameter int SLOT_COUNT = SLOT_COUNT_DEF,
  parameter int SLOT_WIDTH = $clog2(SLOT_COUNT),
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [SLOT_WIDTH-1:0] slot_addr_wr_no,
  input  logic [ADDR_WIDTH-1:0] slot_addr_wr_data,
  input  logic                  slot_addr_wr_valid,
  input  logic [SLOT_WIDTH-1:0] slot_release_no,
  input  logic                  slot_release_valid,
  output logic [ADDR_WIDTH-1:0] inject_rx_desc,
  output logic [SLOT_WIDTH-1:0] inject_rx_desc_slot,
  output logic                  inject_rx_desc_valid,
  input  logic                  inject_rx_desc_ready,
  output logic [SLOT_WIDTH:0]   free_count,
  output logic                  cfg_err,
  output logic                  release_err
);

  inj_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q [SLOT_COUNT];
  logic [ADDR_WIDTH-1:0] addr_d [SLOT_COUNT];
  logic [SLOT_COUNT-1:0] cfg_q, cfg_d;
  logic [SLOT_COUNT-1:0] busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] desc_q, desc_d;
  logic [SLOT_WIDTH-1:0] slot_q, slot_d;
  logic                  valid_q, valid_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  rel_err_q, rel_err_d;

  logic                  push;
  logic [SLOT_WIDTH-1:0] push_idx;
  logic [SLOT_WIDTH-1:0] head;
  logic                  empty;
  logic                  accept, pop;

  assign accept = valid_q && inject_rx_desc_ready;
  assign pop    = (state_q == ST_RUN) && go && !empty
               && (!valid_q || inject_rx_desc_ready);

  slot_free_fifo #(
    .DEPTH (SLOT_COUNT),
    .W     (SLOT_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_idx),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (empty),
    .count_o     (free_count)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cfg_d     = cfg_q;
    busy_d    = busy_q;
    desc_d    = desc_q;
    slot_d    = slot_q;
    valid_d   = valid_q;
    cfg_err_d = cfg_err_q;
    rel_err_d = rel_err_q;
    push      = 1'b0;
    push_idx  = '0;

    if (state_q == ST_IDLE && go) state_d = ST_RUN;

    if (slot_addr_wr_valid) begin
      if (state_q == ST_IDLE) begin
        addr_d[slot_addr_wr_no] = slot_addr_wr_data;
        if (!cfg_q[slot_addr_wr_no]) begin
          cfg_d[slot_addr_wr_no] = 1'b1;
          push     = 1'b1;
          push_idx = slot_addr_wr_no;
        end
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    // Nothing is ever busy in IDLE, so this push never collides with a config push.
    if (slot_release_valid) begin
      if (busy_q[slot_release_no]) begin
        busy_d[slot_release_no] = 1'b0;
        push     = 1'b1;
        push_idx = slot_release_no;
      end else begin
        rel_err_d = 1'b1;
      end
    end

    if (accept) busy_d[slot_q] = 1'b1;

    if (pop) begin
      desc_d  = addr_q[head];
      slot_d  = head;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      busy_q    <= '0;
      desc_q    <= '0;
      slot_q    <= '0;
      valid_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      rel_err_q <= 1'b0;
      for (int i = 0; i < SLOT_COUNT; i++) addr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      busy_q    <= busy_d;
      desc_q    <= desc_d;
      slot_q    <= slot_d;
      valid_q   <= valid_d;
      cfg_err_q <= cfg_err_d;
      rel_err_q <= rel_err_d;
      addr_q    <= addr_d;
    end
  end

  assign inject_rx_desc       = desc_q;
  assign inject_rx_desc_slot  = slot_q;
  assign inject_rx_desc_valid = valid_q;
  assign cfg_err              = cfg_err_q;
  assign release_err          = rel_err_q;

endmodule

// File: tb/tb_rx_slot_desc_injector.sv
// Directed bench for rx_slot_desc_injector with immediate-assertion checks.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_rx_slot_desc_injector;

  localparam int SC = 16;
  localparam int SW = 4;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [SW-1:0] wr_no;
  logic [AW-1:0] wr_data;
  logic          wr_valid;
  logic [SW-1:0] rel_no;
  logic          rel_valid;
  logic [AW-1:0] desc;
  logic [SW-1:0] desc_slot;
  logic          desc_valid;
  logic          ready;
  logic [SW:0]   fcount;
  logic          cfg_err;
  logic          rel_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rx_slot_desc_injector #(
    .SLOT_COUNT (SC),
    .SLOT_WIDTH (SW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .go                   (go),
    .slot_addr_wr_no      (wr_no),
    .slot_addr_wr_data    (wr_data),
    .slot_addr_wr_valid   (wr_valid),
    .slot_release_no      (rel_no),
    .slot_release_valid   (rel_valid),
    .inject_rx_desc       (desc),
    .inject_rx_desc_slot  (desc_slot),
    .inject_rx_desc_valid (desc_valid),
    .inject_rx_desc_ready (ready),
    .free_count           (fcount),
    .cfg_err              (cfg_err),
    .release_err          (rel_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_desc(input string tag, input logic v,
                          input logic [AW-1:0] d, input logic [SW-1:0] s,
                          input logic [SW:0] fc);
    chk({tag, ".valid"}, 32'(desc_valid), 32'(v));
    if (v) begin
      chk({tag, ".desc"}, 32'(desc), 32'(d));
      chk({tag, ".slot"}, 32'(desc_slot), 32'(s));
    end
    chk({tag, ".fc"}, 32'(fcount), 32'(fc));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 32'(desc_valid), 32'd0);
    chk({tag, ".desc"}, 32'(desc), 32'd0);
    chk({tag, ".slot"}, 32'(desc_slot), 32'd0);
    chk({tag, ".fc"}, 32'(fcount), 32'd0);
    chk({tag, ".cfg_err"}, 32'(cfg_err), 32'd0);
    chk({tag, ".rel_err"}, 32'(rel_err), 32'd0);
  endtask

  task automatic cfg(input int n, input int a);
    wr_valid = 1'b1;
    wr_no    = SW'(n);
    wr_data  = AW'(a);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic rel(input int n);
    rel_valid = 1'b1;
    rel_no    = SW'(n);
    step();
    rel_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; ready = 1'b0;
    wr_no = '0; wr_data = '0; wr_valid = 1'b0;
    rel_no = '0; rel_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_reset("reset");

    // Basic issue
    cfg(0, 'h10); cfg(1, 'h20); cfg(2, 'h30); cfg(3, 'h40);
    chk("cfg.fc", 32'(fcount), 32'd4);
    go = 1'b1; ready = 1'b1;
    step();
    chk("run.entry.valid", 32'(desc_valid), 32'd0);
    step(); chk_desc("basic0", 1'b1, 'h10, 0, 3);
    step(); chk_desc("basic1", 1'b1, 'h20, 1, 2);
    step(); chk_desc("basic2", 1'b1, 'h30, 2, 1);
    step(); chk_desc("basic3", 1'b1, 'h40, 3, 0);
    step(); chk_desc("basic.drain", 1'b0, '0, '0, 0);

    // Recycle slot 2, then release it again while it sits in the output reg
    rel_valid = 1'b1; rel_no = 4'd2;
    step();
    chk_desc("recycle.push", 1'b0, '0, '0, 1);
    step();
    rel_valid = 1'b0;
    chk_desc("recycle.issue", 1'b1, 'h30, 2, 0);
    chk("recycle.rel_err", 32'(rel_err), 32'd1);
    step();
    chk_desc("recycle.accept", 1'b0, '0, '0, 0);

    // Simultaneous release and pop
    ready = 1'b0;
    rel(3);
    chk_desc("sim.push3", 1'b0, '0, '0, 1);
    rel(0);
    chk_desc("sim.rel0_pop3", 1'b1, 'h40, 3, 1);
    ready = 1'b1;
    rel(1);
    chk_desc("sim.rel1_acc3", 1'b1, 'h10, 0, 1);
    step(); chk_desc("sim.issue1", 1'b1, 'h20, 1, 0);
    step(); chk_desc("sim.drain", 1'b0, '0, '0, 0);

    // Backpressure with go dropped while slots accumulate
    go = 1'b0; ready = 1'b0;
    rel(0); rel(1);
    chk_desc("bp.go_low", 1'b0, '0, '0, 2);
    go = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk_desc($sformatf("bp.hold%0d", i), 1'b1, 'h10, 0, 1);
      if (i < 4) step();
    end
    ready = 1'b1;
    step(); chk_desc("bp.second", 1'b1, 'h20, 1, 0);
    step(); chk_desc("bp.drain", 1'b0, '0, '0, 0);

    // Config write in RUN is ignored
    cfg(3, 'h7f);
    chk("run_cfg.cfg_err", 32'(cfg_err), 32'd1);
    chk("run_cfg.fc", 32'(fcount), 32'd0);
    rel(3);
    step(); chk_desc("run_cfg.table", 1'b1, 'h40, 3, 0);
    step(); chk_desc("run_cfg.drain", 1'b0, '0, '0, 0);

    // Reset mid-run with a descriptor presented and slots busy
    ready = 1'b0;
    rel(0);
    step(); chk_desc("rst.pre", 1'b1, 'h10, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("rst.mid");
    ready = 1'b1;
    rel(1);
    chk("rst.rel_err", 32'(rel_err), 32'd1);
    for (int i = 0; i < 4; i++) step();
    chk_desc("rst.no_desc", 1'b0, '0, '0, 0);

    // Rewrite of a configured slot in IDLE pushes only once
    go = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cfg(0, 'h11);
    cfg(0, 'h55);
    chk("rewrite.fc", 32'(fcount), 32'd1);
    go = 1'b1;
    step();
    step(); chk_desc("rewrite.issue", 1'b1, 'h55, 0, 0);
    step(); chk_desc("rewrite.single", 1'b0, '0, '0, 0);
    step(); chk_desc("rewrite.quiet", 1'b0, '0, '0, 0);
    chk("rewrite.cfg_err", 32'(cfg_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
